// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, execute redirect and the
// valid/ready link to decode. The fetch unit uses the master view.
interface if_fetch_unit_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   mem_addr;
    logic [31:0]   mem_inst;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_pc;
    logic [31:0]   id_inst;
    logic [CW-1:0] q_count;

    modport master (
        output mem_addr,
        input  mem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_inst,
        output q_count
    );

    modport slave (
        input  mem_addr,
        output mem_inst,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_inst,
        input  q_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register addressing a combinational
// instruction memory, plus a small FIFO of {pc, inst} pairs feeding decode.
// A redirect empties the FIFO and reloads the PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    if_fetch_unit_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   pc_reg,     pc_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;

    logic          push;
    logic          pop;
    logic          not_empty;
    logic [63:0]   entry_q [QDEPTH];
    logic [63:0]   head;

    // Redirect pre-empts both queue operations; a full queue never accepts a
    // push even if the head leaves in the same cycle.
    assign not_empty = (count_reg != '0);
    assign push      = rdy && !bus.redirect_valid && (count_reg < CW'(QDEPTH));
    assign pop       = rdy && !bus.redirect_valid && not_empty && bus.id_ready;

    // One storage register per FIFO slot; only the slot under wr_ptr loads.
    // Storage needs no reset: an empty queue masks the head to zero.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        logic [63:0] entry_reg;

        // Capture {pc, inst} when this slot is the write target.
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
                entry_reg <= {pc_reg, bus.mem_inst};
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    assign head = entry_q[rd_ptr_reg];

    // Next-state for PC, pointers and occupancy; rdy=0 holds everything.
    always_comb begin
        pc_next     = pc_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (rdy) begin
            if (bus.redirect_valid) begin
                pc_next     = bus.redirect_pc & 32'hFFFF_FFFC;
                wr_ptr_next = '0;
                rd_ptr_next = '0;
                count_next  = '0;
            end else begin
                if (push) begin
                    pc_next     = pc_reg + 32'd4;
                    wr_ptr_next = wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_next = rd_ptr_reg + PW'(1);
                end
                if (push && !pop) begin
                    count_next = count_reg + CW'(1);
                end else if (pop && !push) begin
                    count_next = count_reg - CW'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg     <= RESET_PC;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            pc_reg     <= pc_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Outputs: head is hidden (zero) while the queue is empty.
    always_comb begin
        bus.mem_addr = pc_reg;
        bus.id_valid = not_empty;
        bus.id_pc    = not_empty ? head[63:32] : 32'd0;
        bus.id_inst  = not_empty ? head[31:0]  : 32'd0;
        bus.q_count  = count_reg;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, back-pressure, redirect,
// pause, asynchronous reset and PC wrap (second instance, high RESET_PC).
module tb_if_fetch_unit;
    logic clk;
    logic rst;
    logic rdy;

    int n_checks = 0;
    int n_fails  = 0;

    if_fetch_unit_if #(.QDEPTH(4)) bus ();
    if_fetch_unit_if #(.QDEPTH(4)) bus2 ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus2)
    );

    // Memory model: each word is the complement of its address.
    assign bus.mem_inst  = ~bus.mem_addr;
    assign bus2.mem_inst = ~bus2.mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed %h required %h", tag, observed, expected);
        end else begin
            $display("ok   %s = %h", tag, observed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one rising edge, then release mid-cycle.
    task automatic apply_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        rst                 = 1'b0;
        rdy                 = 1'b1;
        bus.id_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus2.id_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'd0;

        // Reset state
        step();
        check_value("rst_mem_addr", bus.mem_addr, 32'd0);
        check_value("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check_value("rst_id_pc", bus.id_pc, 32'd0);
        check_value("rst_id_inst", bus.id_inst, 32'd0);
        check_value("rst_q_count", 32'(bus.q_count), 32'd0);
        check_value("rst2_mem_addr", bus2.mem_addr, 32'hFFFF_FFF8);

        // Test 1 + 6: streaming with id_ready=1, both instances
        bus.id_ready = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = 32'(i * 4);
            check_value("t1_id_valid", 32'(bus.id_valid), 32'd1);
            check_value("t1_id_pc", bus.id_pc, exp_pc);
            check_value("t1_id_inst", bus.id_inst, ~exp_pc);
            check_value("t1_q_count", 32'(bus.q_count), 32'd1);
            exp_pc = 32'hFFFF_FFF8 + 32'(i * 4);
            check_value("t6_id_pc", bus2.id_pc, exp_pc);
        end

        // Test 2: back-pressure fills the queue, then drains in order
        bus.id_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 10; i++) step();
        check_value("t2_q_count_full", 32'(bus.q_count), 32'd4);
        check_value("t2_mem_addr_hold", bus.mem_addr, 32'h10);
        bus.id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_value("t2_id_valid", 32'(bus.id_valid), 32'd1);
            check_value("t2_id_pc", bus.id_pc, 32'(k * 4));
            step();
        end

        // Test 3: redirect with three entries queued
        bus.id_ready = 1'b0;
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        check_value("t3_q_count_pre", 32'(bus.q_count), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h83;
        step();
        bus.redirect_valid = 1'b0;
        check_value("t3_id_valid_flush", 32'(bus.id_valid), 32'd0);
        check_value("t3_q_count_flush", 32'(bus.q_count), 32'd0);
        check_value("t3_mem_addr", bus.mem_addr, 32'h80);
        step();
        check_value("t3_id_valid_tgt", 32'(bus.id_valid), 32'd1);
        check_value("t3_id_pc_tgt", bus.id_pc, 32'h80);
        check_value("t3_id_inst_tgt", bus.id_inst, ~32'h80);

        // Test 4: rdy=0 freezes everything, including redirect and pop
        bus.id_ready = 1'b1;
        apply_reset();
        step();
        step();
        check_value("t4_id_pc_pre", bus.id_pc, 32'h4);
        rdy                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("t4_mem_addr_hold", bus.mem_addr, 32'h8);
            check_value("t4_q_count_hold", 32'(bus.q_count), 32'd1);
            check_value("t4_id_pc_hold", bus.id_pc, 32'h4);
        end
        rdy                = 1'b1;
        bus.redirect_valid = 1'b0;
        step();
        check_value("t4_id_pc_resume", bus.id_pc, 32'h8);
        check_value("t4_mem_addr_resume", bus.mem_addr, 32'hC);

        // Test 5: asynchronous reset between edges
        bus.id_ready = 1'b0;
        apply_reset();
        step();
        step();
        check_value("t5_q_count_pre", 32'(bus.q_count), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("t5_id_valid_async", 32'(bus.id_valid), 32'd0);
        check_value("t5_mem_addr_async", bus.mem_addr, 32'd0);
        check_value("t5_q_count_async", 32'(bus.q_count), 32'd0);
        check_value("t5_mem_addr2_async", bus2.mem_addr, 32'hFFFF_FFF8);
        step();
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
